// File: rtl/storage_bist.sv
// Word read/write pattern BIST across N_BLOCKS memories sharing one
// one-cycle-latency port; reports progress on a 16-bit checkbits code bus.
module storage_bist #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_BLOCKS = 2,
    parameter logic [31:0] SEED     = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start,
    input  logic              mode,
    output logic [3:0]        mem_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3:0]        fail_block,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [15:0]       checkbits
);

    typedef enum logic [2:0] {
        StIdle, StStartBlk, StWrite, StRead, StCheck, StBlkPass, StFail, StDone
    } state_e;

    localparam logic [DATA_W-1:0] SeedT    = DATA_W'(SEED);
    localparam logic [ADDR_W-1:0] LastAddr = '1;
    localparam logic [3:0]        LastBlk  = 4'(N_BLOCKS - 1);
    localparam int                CbW      = 2 * (DATA_W / 2);

    // Odd DATA_W leaves the checkerboard MSB at 0 before inversion.
    function automatic logic [DATA_W-1:0] pattern(input logic m, input logic ph,
                                                  input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] c;
        if (!m) return DATA_W'(a) ^ SeedT;
        c = '0;
        for (int i = 0; i < CbW; i++) c[i] = (i[0] == a[0]);
        return ph ? ~c : c;
    endfunction

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic              phase_q, phase_d;
    logic [3:0]        blk_q, blk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [3:0]        fail_block_q, fail_block_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [15:0]       checkbits_q, checkbits_d;
    logic              mismatch;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        phase_d      = phase_q;
        blk_d        = blk_q;
        addr_d       = addr_q;
        rd_pend_d    = 1'b0;
        rd_addr_d    = addr_q;
        wdata_d      = wdata_q;
        pass_d       = pass_q;
        fail_block_d = fail_block_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        checkbits_d  = checkbits_q;

        // Only reads still owned by READ/CHECK are compared; a read in flight
        // when FAIL is entered is dropped.
        mismatch = rd_pend_q && (state_q == StRead || state_q == StCheck) &&
                   (mem_rdata != pattern(mode_q, phase_q, rd_addr_q));

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StStartBlk;
                    mode_d       = mode;
                    phase_d      = 1'b0;
                    blk_d        = 4'd0;
                    addr_d       = '0;
                    pass_d       = 1'b0;
                    fail_block_d = '0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                end
            end
            StStartBlk: begin
                state_d = StWrite;
                addr_d  = '0;
            end
            StWrite: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == LastAddr) state_d = StRead;
            end
            StRead: begin
                rd_pend_d = 1'b1;
                addr_d    = addr_q + ADDR_W'(1);
                if (mismatch) state_d = StFail;
                else if (addr_q == LastAddr) state_d = StCheck;
            end
            StCheck: begin
                if (mismatch) begin
                    state_d = StFail;
                end else if (mode_q && !phase_q) begin
                    state_d = StWrite;
                    phase_d = 1'b1;
                    addr_d  = '0;
                end else begin
                    state_d = StBlkPass;
                end
            end
            StBlkPass: begin
                if (blk_q < LastBlk) begin
                    state_d = StStartBlk;
                    blk_d   = blk_q + 4'd1;
                    phase_d = 1'b0;
                    addr_d  = '0;
                end else begin
                    state_d = StDone;
                    pass_d  = 1'b1;
                end
            end
            StFail:  state_d = StDone;
            default: state_d = StIdle;
        endcase

        if (mismatch) begin
            fail_block_d = blk_q;
            fail_addr_d  = rd_addr_q;
            fail_data_d  = mem_rdata;
        end

        // Outputs are registered from the next state so they line up with it.
        mem_en_d = (state_d == StWrite) || (state_d == StRead);
        mem_we_d = (state_d == StWrite);
        if (state_d == StWrite) wdata_d = pattern(mode_d, phase_d, addr_d);
        busy_d = !((state_d == StIdle) || (state_d == StDone));
        done_d = (state_d == StDone);
        case (state_d)
            StStartBlk: checkbits_d = {8'hA0, blk_d, 4'h0};
            StBlkPass:  checkbits_d = {8'hAB, blk_d, 4'h1};
            StFail:     checkbits_d = {8'hAB, blk_d, 4'h0};
            default:    checkbits_d = checkbits_q;
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            phase_q      <= 1'b0;
            blk_q        <= 4'd0;
            addr_q       <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_block_q <= 4'd0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            checkbits_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            blk_q        <= blk_d;
            addr_q       <= addr_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            wdata_q      <= wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_block_q <= fail_block_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            checkbits_q  <= checkbits_d;
        end
    end

    assign mem_sel    = blk_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_block = fail_block_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign checkbits  = checkbits_q;

endmodule

// File: tb/tb_storage_bist.sv
// Directed bench for storage_bist: two 16-word memories with injectable read faults.
module tb_storage_bist;

    logic        clock = 1'b0;
    logic        resetb, start, mode;
    logic [3:0]  mem_sel, fail_block;
    logic        mem_en, mem_we, busy, done, pass;
    logic [3:0]  mem_addr, fail_addr;
    logic [31:0] mem_wdata, mem_rdata, fail_data;
    logic [15:0] checkbits;

    storage_bist #(.ADDR_W(4), .DATA_W(32), .N_BLOCKS(2), .SEED(32'h0)) dut (
        .clock(clock), .resetb(resetb), .start(start), .mode(mode),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .pass(pass), .fail_block(fail_block), .fail_addr(fail_addr),
        .fail_data(fail_data), .checkbits(checkbits)
    );

    always #5 clock = ~clock;

    // 0: clean, 1: block 1 addr 7 bit 3 stuck high, 2: block 0 addr 15 bit 4 flipped
    int          fault = 0;
    logic [31:0] mem [2][16];
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_sel[0]][mem_addr] <= mem_wdata;
            end else begin
                logic [31:0] d;
                d = mem[mem_sel[0]][mem_addr];
                if (fault == 1 && mem_sel == 4'd1 && mem_addr == 4'd7) d = d | 32'h8;
                if (fault == 2 && mem_sel == 4'd0 && mem_addr == 4'd15) d = d ^ 32'h10;
                mem_rdata <= d;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] cb_q[$];
    logic [31:0] wr_q[$];
    int          busy_cyc, en_after_fail, timed_out;
    logic        first_done, first_pass;

    // Pulses start with the given mode and samples every negedge until done.
    // At iteration poke, start is re-asserted and mode inverted for one cycle.
    task automatic run(input logic m, input int poke);
        logic [15:0] last_cb;
        logic        fail_seen;
        cb_q.delete();
        wr_q.delete();
        busy_cyc = 0; en_after_fail = 0; timed_out = 1; fail_seen = 1'b0;
        last_cb = checkbits;
        start = 1'b1;
        mode  = m;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (i == poke) begin
                start = 1'b1;
                mode  = ~mode;
            end else begin
                start = 1'b0;
            end
            if (i == 0) begin
                first_done = done;
                first_pass = pass;
            end
            if (busy) busy_cyc++;
            if (checkbits !== last_cb) cb_q.push_back(checkbits);
            last_cb = checkbits;
            if (mem_en && mem_we) wr_q.push_back(mem_wdata);
            if (checkbits[15:8] == 8'hAB && checkbits[3:0] == 4'h0) fail_seen = 1'b1;
            if (fail_seen && mem_en) en_after_fail++;
            if (done) begin
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        mode  = 1'b0;
        check_eq("run_timeout", 32'(timed_out), 32'd0);
    endtask

    function automatic logic [31:0] cb_pat(input int a, input int ph);
        logic [31:0] c;
        c = (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
        return (ph != 0) ? ~c : c;
    endfunction

    initial begin
        int          nbad;
        logic [31:0] cb0, cb1, cb2, cb3;
        resetb = 1'b0; start = 1'b0; mode = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_checkbits", 32'(checkbits), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_en", 32'(mem_en), 32'd0);
        resetb = 1'b1;
        @(negedge clock);

        // Mode 0 clean pass
        run(1'b0, -1);
        check_eq("m0_cb_count", 32'(cb_q.size()), 32'd4);
        if (cb_q.size() == 4) begin
            cb0 = 32'(cb_q[0]); cb1 = 32'(cb_q[1]); cb2 = 32'(cb_q[2]); cb3 = 32'(cb_q[3]);
            check_eq("m0_cb0", cb0, 32'hA000);
            check_eq("m0_cb1", cb1, 32'hAB01);
            check_eq("m0_cb2", cb2, 32'hA010);
            check_eq("m0_cb3", cb3, 32'hAB11);
        end
        check_eq("m0_done", 32'(done), 32'd1);
        check_eq("m0_pass", 32'(pass), 32'd1);
        check_eq("m0_cycles", 32'(busy_cyc), 32'd70);
        nbad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== 32'(i % 16)) nbad++;
        check_eq("m0_wr_count", 32'(wr_q.size()), 32'd32);
        check_eq("m0_wr_data", 32'(nbad), 32'd0);

        // Mode 1 clean pass, started from DONE
        run(1'b1, -1);
        check_eq("restart_done_clr", 32'(first_done), 32'd0);
        check_eq("restart_pass_clr", 32'(first_pass), 32'd0);
        check_eq("m1_wr_count", 32'(wr_q.size()), 32'd64);
        if (wr_q.size() >= 2) begin
            check_eq("m1_wr0", wr_q[0], 32'h5555_5555);
            check_eq("m1_wr1", wr_q[1], 32'hAAAA_AAAA);
        end
        nbad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== cb_pat(i % 16, (i % 32) / 16)) nbad++;
        check_eq("m1_wr_data", 32'(nbad), 32'd0);
        check_eq("m1_pass", 32'(pass), 32'd1);
        check_eq("m1_cycles", 32'(busy_cyc), 32'd136);

        // Stuck bit in block 1 at address 7
        fault = 1;
        run(1'b0, -1);
        check_eq("f1_cb_last", 32'(checkbits), 32'hAB10);
        check_eq("f1_fail_block", 32'(fail_block), 32'd1);
        check_eq("f1_fail_addr", 32'(fail_addr), 32'd7);
        check_eq("f1_fail_data", fail_data, 32'h0000_000F);
        check_eq("f1_pass", 32'(pass), 32'd0);
        check_eq("f1_done", 32'(done), 32'd1);
        check_eq("f1_en_after", 32'(en_after_fail), 32'd0);
        check_eq("f1_cb_count", 32'(cb_q.size()), 32'd4);

        // Corrupt last address of block 0, caught in CHECK
        fault = 2;
        run(1'b0, -1);
        check_eq("f2_cb_last", 32'(checkbits), 32'hAB00);
        check_eq("f2_fail_block", 32'(fail_block), 32'd0);
        check_eq("f2_fail_addr", 32'(fail_addr), 32'hF);
        check_eq("f2_fail_data", fail_data, 32'h0000_001F);
        check_eq("f2_pass", 32'(pass), 32'd0);
        check_eq("f2_cb_count", 32'(cb_q.size()), 32'd2);
        fault = 0;

        // Reset asserted during READ of block 1
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (checkbits !== 16'hA010 && n < 200) begin
                @(negedge clock);
                n++;
            end
            check_eq("rst_mid_reach_blk1", 32'(checkbits), 32'hA010);
        end
        repeat (20) @(negedge clock);
        check_eq("rst_mid_in_read", 32'({mem_en, mem_we}), 32'b10);
        resetb = 1'b0;
        #1;
        check_eq("rst_mid_checkbits", 32'(checkbits), 32'h0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_mem_en", 32'(mem_en), 32'd0);
        check_eq("rst_mid_mem_sel", 32'(mem_sel), 32'd0);
        nbad = 0;
        repeat (3) begin
            @(negedge clock);
            if (mem_en) nbad++;
        end
        check_eq("rst_mid_no_access", 32'(nbad), 32'd0);
        resetb = 1'b1;
        @(negedge clock);
        run(1'b0, -1);
        check_eq("post_rst_pass", 32'(pass), 32'd1);
        check_eq("post_rst_cycles", 32'(busy_cyc), 32'd70);
        if (cb_q.size() > 0) check_eq("post_rst_cb0", 32'(cb_q[0]), 32'hA000);

        // Start re-asserted with mode toggled mid-test
        run(1'b0, 30);
        check_eq("poke_pass", 32'(pass), 32'd1);
        check_eq("poke_cycles", 32'(busy_cyc), 32'd70);
        check_eq("poke_wr_count", 32'(wr_q.size()), 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
